rgb_fade_sequencer: RTL and testbench

- Sequencer between the per-channel encoder values and the three PWM generators of the RGB mixer.
- MANUAL mode: forwards the three encoder levels to the PWM level inputs.
- AUTO mode: steps through a 4-slot colour palette, ramping each channel by 1 LSB per tick, holding each colour for a programmable time.
- Palette slots are loaded from the current manual colour with a store button.

---
 rtl/rgb_pkg.sv | 35 +++
 rtl/rgb_fade_sequencer_ramp_channel.sv | 28 ++
 rtl/rgb_fade_sequencer.sv | 144 ++++++++++++++
 tb/tb_rgb_fade_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pkg.sv
// Shared types and constants for the RGB fade sequencer: FSM states, widths and
// the palette that is restored on reset.
package rgb_pkg;

   localparam int NUM_CH    = 3;
   localparam int NUM_SLOTS = 4;
   localparam int LEVEL_W   = 8;

   typedef enum logic [1:0] {
      MANUAL = 2'd0,
      FADE   = 2'd1,
      HOLD   = 2'd2
   } state_t;

   typedef logic [LEVEL_W-1:0]           level_t;
   typedef logic [$clog2(NUM_SLOTS)-1:0] slot_t;
   typedef level_t [NUM_CH-1:0]          color_t;   // [0] = red, [1] = green, [2] = blue

   localparam color_t DEF_SLOT0 = {8'h00, 8'h00, 8'hFF};
   localparam color_t DEF_SLOT1 = {8'h00, 8'hFF, 8'h00};
   localparam color_t DEF_SLOT2 = {8'hFF, 8'h00, 8'h00};
   localparam color_t DEF_SLOT3 = {8'hFF, 8'hFF, 8'hFF};

   function automatic color_t default_color(input slot_t slot);
      color_t c;
      case (slot)
         2'd0:    c = DEF_SLOT0;
         2'd1:    c = DEF_SLOT1;
         2'd2:    c = DEF_SLOT2;
         default: c = DEF_SLOT3;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/rgb_fade_sequencer_ramp_channel.sv
// One colour channel: an 8-bit level that is either loaded directly or walked one
// LSB per step toward a target, never overshooting it.
module ramp_channel
   import rgb_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   load,
   input  level_t load_val,
   input  logic   step,
   input  level_t target,
   output level_t level,
   output logic   at_target
);

   assign at_target = (level == target);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level <= '0;
      end else if (load) begin
         level <= load_val;
      end else if (step && !at_target) begin
         level <= (level < target) ? level + LEVEL_W'(1) : level - LEVEL_W'(1);
      end
   end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Sits between the encoders and the PWM generators: passes manual levels through,
// or cycles a 4-slot palette with linear fades and timed holds.
module rgb_fade_sequencer
   import rgb_pkg::*;
#(
   parameter int DIV        = 1000,
   parameter int HOLD_TICKS = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] man_level0,
   input  logic [7:0] man_level1,
   input  logic [7:0] man_level2,
   input  logic       mode_btn,
   input  logic       store_btn,
   output logic [7:0] level0,
   output logic [7:0] level1,
   output logic [7:0] level2,
   output logic       auto_active,
   output logic [1:0] slot_idx
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int HW = $clog2(HOLD_TICKS) + 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);

   state_t        state, state_nxt;
   slot_t         tgt_slot, tgt_slot_nxt;
   slot_t         wr_ptr, wr_ptr_nxt;
   logic [PW-1:0] presc, presc_nxt;
   logic [HW-1:0] hold_cnt, hold_cnt_nxt;
   logic          mode_q, store_q;
   logic          mode_edge, store_edge;
   logic          tick, all_at, store_en, ramp_load, ramp_step;
   color_t        palette [NUM_SLOTS];
   color_t        man_color, tgt_color;
   level_t        cur_level [NUM_CH];
   logic [NUM_CH-1:0] ch_at;

   assign man_color  = {man_level2, man_level1, man_level0};
   assign tgt_color  = palette[tgt_slot];
   assign mode_edge  = mode_btn & ~mode_q;
   assign store_edge = store_btn & ~store_q;
   assign tick       = (state != MANUAL) && (presc == PRESC_LAST);
   assign all_at     = &ch_at;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= MANUAL;
         tgt_slot <= '0;
         wr_ptr   <= '0;
         presc    <= '0;
         hold_cnt <= '0;
         mode_q   <= 1'b1;   // a button held through reset release must not count as a press
         store_q  <= 1'b1;
      end else begin
         state    <= state_nxt;
         tgt_slot <= tgt_slot_nxt;
         wr_ptr   <= wr_ptr_nxt;
         presc    <= presc_nxt;
         hold_cnt <= hold_cnt_nxt;
         mode_q   <= mode_btn;
         store_q  <= store_btn;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < NUM_SLOTS; s++) palette[s] <= default_color(slot_t'(s));
      end else if (store_en) begin
         palette[wr_ptr] <= man_color;
      end
   end

   always_comb begin
      state_nxt    = state;
      tgt_slot_nxt = tgt_slot;
      wr_ptr_nxt   = wr_ptr;
      hold_cnt_nxt = hold_cnt;
      presc_nxt    = (state == MANUAL || tick) ? '0 : presc + 1'b1;
      store_en     = 1'b0;
      ramp_load    = 1'b0;
      ramp_step    = 1'b0;
      case (state)
         MANUAL: begin
            // On the entry edge levels are kept, so the fade starts from what is shown.
            ramp_load = !mode_edge;
            if (store_edge) begin
               store_en   = 1'b1;
               wr_ptr_nxt = wr_ptr + 2'd1;
            end
            if (mode_edge) begin
               state_nxt    = FADE;
               tgt_slot_nxt = '0;
            end
         end
         FADE: begin
            if (mode_edge) begin
               state_nxt = MANUAL;
            end else if (all_at) begin
               state_nxt    = HOLD;
               hold_cnt_nxt = '0;
            end else begin
               ramp_step = tick;
            end
         end
         HOLD: begin
            if (mode_edge) begin
               state_nxt = MANUAL;
            end else if (tick) begin
               if (hold_cnt == HOLD_LAST) begin
                  state_nxt    = FADE;
                  tgt_slot_nxt = tgt_slot + 2'd1;
               end else begin
                  hold_cnt_nxt = hold_cnt + 1'b1;
               end
            end
         end
         default: state_nxt = MANUAL;
      endcase
      if (state_nxt != state) presc_nxt = '0;
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      ramp_channel u_ramp (
         .clk       (clk),
         .rst_n     (reset),
         .load      (ramp_load),
         .load_val  (man_color[i]),
         .step      (ramp_step),
         .target    (tgt_color[i]),
         .level     (cur_level[i]),
         .at_target (ch_at[i])
      );
   end

   assign level0      = cur_level[0];
   assign level1      = cur_level[1];
   assign level2      = cur_level[2];
   assign auto_active = (state != MANUAL);
   assign slot_idx    = (state == MANUAL) ? wr_ptr : tgt_slot;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed bench for rgb_fade_sequencer with DIV=4, HOLD_TICKS=2; expected levels
// and slot indices are hand-computed from the tick/hold timing.
module tb_rgb_fade_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] man_level0, man_level1, man_level2;
   logic       mode_btn, store_btn;
   logic [7:0] level0, level1, level2;
   logic       auto_active;
   logic [1:0] slot_idx;

   int checks = 0;
   int errors = 0;

   rgb_fade_sequencer #(.DIV(4), .HOLD_TICKS(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .man_level0  (man_level0),
      .man_level1  (man_level1),
      .man_level2  (man_level2),
      .mode_btn    (mode_btn),
      .store_btn   (store_btn),
      .level0      (level0),
      .level1      (level1),
      .level2      (level2),
      .auto_active (auto_active),
      .slot_idx    (slot_idx)
   );

   always #5 clk = ~clk;

   task automatic set_man(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      man_level0 = a;
      man_level1 = b;
      man_level2 = c;
   endtask

   // Returns at the falling edge right after the edge that sees the press.
   task automatic press_mode();
      mode_btn = 1'b1;
      @(negedge clk);
      mode_btn = 1'b0;
   endtask

   task automatic press_store();
      store_btn = 1'b1;
      @(negedge clk);
      store_btn = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({level0, level1, level2} !== 24'h000000) begin
         errors++; $display("FAIL reset_levels: got %h want 000000", {level0, level1, level2});
      end
      checks++;
      if (auto_active !== 1'b0 || slot_idx !== 2'd0) begin
         errors++; $display("FAIL reset_ctrl: auto=%b slot=%0d want 0/0", auto_active, slot_idx);
      end
      reset = 1'b1;          // mode_btn still held high
      repeat (3) @(negedge clk);
      checks++;
      if (auto_active !== 1'b0) begin
         errors++; $display("FAIL held_mode_no_auto: auto=%b want 0", auto_active);
      end
      mode_btn = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_manual();
      set_man(8'h12, 8'h34, 8'h56);
      #1;
      checks++;
      if ({level0, level1, level2} !== 24'h000000) begin
         errors++; $display("FAIL manual_latency: got %h want 000000", {level0, level1, level2});
      end
      @(negedge clk);
      checks++;
      if ({level0, level1, level2} !== 24'h123456 || auto_active !== 1'b0) begin
         errors++; $display("FAIL manual_pass: got %h auto=%b want 123456 auto=0",
                            {level0, level1, level2}, auto_active);
      end
   endtask

   task automatic test_auto_fade();
      set_man(8'h00, 8'h00, 8'h00);
      @(negedge clk);
      press_mode();                       // cycle 0
      checks++;
      if (auto_active !== 1'b1 || slot_idx !== 2'd0 || level0 !== 8'h00) begin
         errors++; $display("FAIL fade_entry: auto=%b slot=%0d l0=%h want 1/0/00",
                            auto_active, slot_idx, level0);
      end
      repeat (3) @(negedge clk);          // cycle 3
      checks++;
      if (level0 !== 8'h00) begin
         errors++; $display("FAIL fade_pre_tick: l0=%h want 00", level0);
      end
      @(negedge clk);                     // cycle 4
      checks++;
      if (level0 !== 8'h01) begin
         errors++; $display("FAIL fade_first_tick: l0=%h want 01", level0);
      end
      repeat (1015) @(negedge clk);       // cycle 1019
      checks++;
      if (level0 !== 8'hFE) begin
         errors++; $display("FAIL fade_c1019: l0=%h want FE", level0);
      end
      @(negedge clk);                     // cycle 1020
      checks++;
      if ({level0, level1, level2} !== 24'hFF0000 || auto_active !== 1'b1) begin
         errors++; $display("FAIL fade_reach: got %h auto=%b want FF0000 auto=1",
                            {level0, level1, level2}, auto_active);
      end
      repeat (8) @(negedge clk);          // cycle 1028, last HOLD cycle
      checks++;
      if (slot_idx !== 2'd0 || {level0, level1, level2} !== 24'hFF0000) begin
         errors++; $display("FAIL hold_c1028: slot=%0d lv=%h want 0 FF0000",
                            slot_idx, {level0, level1, level2});
      end
      @(negedge clk);                     // cycle 1029
      checks++;
      if (slot_idx !== 2'd1 || auto_active !== 1'b1) begin
         errors++; $display("FAIL hold_exit: slot=%0d auto=%b want 1/1", slot_idx, auto_active);
      end
      repeat (4) @(negedge clk);          // cycle 1033
      checks++;
      if ({level0, level1, level2} !== 24'hFE0100) begin
         errors++; $display("FAIL fade_slot1: got %h want FE0100", {level0, level1, level2});
      end
   endtask

   task automatic test_mode_abort();
      set_man(8'hAA, 8'hBB, 8'hCC);
      press_mode();
      checks++;
      if (auto_active !== 1'b0 || slot_idx !== 2'd0 || {level0, level1, level2} !== 24'hFE0100) begin
         errors++; $display("FAIL abort_edge: auto=%b slot=%0d lv=%h want 0/0/FE0100",
                            auto_active, slot_idx, {level0, level1, level2});
      end
      @(negedge clk);
      checks++;
      if ({level0, level1, level2} !== 24'hAABBCC) begin
         errors++; $display("FAIL abort_load: got %h want AABBCC", {level0, level1, level2});
      end
   endtask

   task automatic test_store_and_hold();
      set_man(8'h10, 8'h20, 8'h30);
      press_store();
      set_man(8'h40, 8'h50, 8'h60);
      press_store();
      checks++;
      if (slot_idx !== 2'd2) begin
         errors++; $display("FAIL store_ptr: slot=%0d want 2", slot_idx);
      end
      press_mode();                       // cycle 0
      repeat (4) @(negedge clk);          // cycle 4
      checks++;
      if ({level0, level1, level2} !== 24'h3F4F5F) begin
         errors++; $display("FAIL store_fade_dir: got %h want 3F4F5F", {level0, level1, level2});
      end
      repeat (188) @(negedge clk);        // cycle 192
      checks++;
      if ({level0, level1, level2} !== 24'h102030) begin
         errors++; $display("FAIL store_reach: got %h want 102030", {level0, level1, level2});
      end
      repeat (2) @(negedge clk);          // cycle 194, in HOLD
      set_man(8'h77, 8'h77, 8'h77);
      press_store();                      // cycle 196
      checks++;
      if ({level0, level1, level2} !== 24'h102030 || slot_idx !== 2'd0) begin
         errors++; $display("FAIL hold_store: lv=%h slot=%0d want 102030/0",
                            {level0, level1, level2}, slot_idx);
      end
      repeat (5) @(negedge clk);          // cycle 201
      checks++;
      if (slot_idx !== 2'd1) begin
         errors++; $display("FAIL store_next_slot: slot=%0d want 1", slot_idx);
      end
      repeat (4) @(negedge clk);          // cycle 205
      checks++;
      if ({level0, level1, level2} !== 24'h112131) begin
         errors++; $display("FAIL fade_to_slot1: got %h want 112131", {level0, level1, level2});
      end
      repeat (197) @(negedge clk);        // cycle 402
      checks++;
      if (slot_idx !== 2'd2) begin
         errors++; $display("FAIL slot2_entry: slot=%0d want 2", slot_idx);
      end
      repeat (4) @(negedge clk);          // cycle 406
      checks++;
      if ({level0, level1, level2} !== 24'h3F4F61) begin
         errors++; $display("FAIL slot2_untouched: got %h want 3F4F61", {level0, level1, level2});
      end
      press_mode();
      checks++;
      if (auto_active !== 1'b0 || slot_idx !== 2'd2) begin
         errors++; $display("FAIL wrptr_kept: auto=%b slot=%0d want 0/2", auto_active, slot_idx);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_fade();
      press_mode();
      repeat (10) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({level0, level1, level2} !== 24'h000000 || auto_active !== 1'b0 || slot_idx !== 2'd0) begin
         errors++; $display("FAIL async_reset: lv=%h auto=%b slot=%0d want 000000/0/0",
                            {level0, level1, level2}, auto_active, slot_idx);
      end
      @(negedge clk);
      reset = 1'b1;
      set_man(8'h00, 8'h00, 8'h00);
      @(negedge clk);
      press_mode();
      repeat (4) @(negedge clk);
      checks++;
      if ({level0, level1, level2} !== 24'h010000) begin
         errors++; $display("FAIL palette_default: got %h want 010000", {level0, level1, level2});
      end
      press_mode();
      @(negedge clk);
   endtask

   task automatic test_store_wrap();
      for (int k = 1; k <= 4; k++) begin
         set_man(8'(k), 8'(k), 8'(k));
         press_store();
      end
      set_man(8'h55, 8'h66, 8'h77);
      press_store();
      checks++;
      if (slot_idx !== 2'd1) begin
         errors++; $display("FAIL wrap_ptr: slot=%0d want 1", slot_idx);
      end
      press_mode();                       // cycle 0; slot0 already matches the levels
      checks++;
      if (auto_active !== 1'b1 || slot_idx !== 2'd0) begin
         errors++; $display("FAIL wrap_auto: auto=%b slot=%0d want 1/0", auto_active, slot_idx);
      end
      repeat (8) @(negedge clk);          // cycle 8
      checks++;
      if ({level0, level1, level2} !== 24'h556677 || slot_idx !== 2'd0) begin
         errors++; $display("FAIL wrap_slot0: lv=%h slot=%0d want 556677/0",
                            {level0, level1, level2}, slot_idx);
      end
      @(negedge clk);                     // cycle 9
      checks++;
      if (slot_idx !== 2'd1) begin
         errors++; $display("FAIL wrap_hold_exit: slot=%0d want 1", slot_idx);
      end
   endtask

   initial begin
      reset     = 1'b0;
      mode_btn  = 1'b1;
      store_btn = 1'b0;
      set_man(8'h00, 8'h00, 8'h00);
      test_reset();
      test_manual();
      test_auto_fade();
      test_mode_abort();
      test_store_and_hold();
      test_reset_mid_fade();
      test_store_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
